// File: rtl/load_store_unit_if.sv
// Request/response and DataMemory bus of the load/store unit.
// The slave side is the LSU; the master side is the requester plus the memory.
interface load_store_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_write;
  logic [1:0]              req_size;
  logic                    req_signed;
  logic [ADDR_WIDTH+1:0]   req_addr;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic                    resp_valid;
  logic [DATA_WIDTH-1:0]   resp_rdata;
  logic                    misalign_err;
  logic [ADDR_WIDTH-1:0]   mem_address;
  logic [DATA_WIDTH-1:0]   mem_writeData;
  logic                    mem_writeEnable;
  logic [DATA_WIDTH-1:0]   mem_readData;

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_readData,
    output req_ready, resp_valid, resp_rdata, misalign_err,
           mem_address, mem_writeData, mem_writeEnable
  );

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_readData,
    input  req_ready, resp_valid, resp_rdata, misalign_err,
           mem_address, mem_writeData, mem_writeEnable
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word accesses to a word-wide DataMemory.
// Sub-word stores are done as read-modify-write; loads extract and extend.
module load_store_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input logic              clk,
  input logic              rst,
  load_store_unit_if.slave bus
);

  typedef enum logic [2:0] {IDLE, RD, WR, ACC, RESP} state_t;

  state_t                  state;
  state_t                  stateNext;

  logic [ADDR_WIDTH+1:0]   addrReg;
  logic [1:0]              sizeReg;
  logic                    signedReg;
  logic                    writeReg;
  logic [DATA_WIDTH-1:0]   dataReg;
  logic                    errReg;

  logic                    accept;

  // Half needs bit 0 clear, word needs both low bits clear; size 11 is never legal.
  function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   isMisaligned = 1'b0;
      2'b01:   isMisaligned = off[0];
      2'b10:   isMisaligned = (off != 2'b00);
      default: isMisaligned = 1'b1;
    endcase
  endfunction

  // Shift the addressed lane down to bit 0, then zero- or sign-extend it.
  function automatic logic [DATA_WIDTH-1:0] extractLoad(input logic [DATA_WIDTH-1:0] word,
                                                        input logic [1:0] off,
                                                        input logic [1:0] size,
                                                        input logic sgn);
    logic [DATA_WIDTH-1:0] sh;
    logic signed [7:0]     b;
    logic signed [15:0]    h;
    sh = word >> {off, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    case (size)
      2'b00:   extractLoad = sgn ? DATA_WIDTH'(b) : {{(DATA_WIDTH-8){1'b0}}, sh[7:0]};
      2'b01:   extractLoad = sgn ? DATA_WIDTH'(h) : {{(DATA_WIDTH-16){1'b0}}, sh[15:0]};
      default: extractLoad = word;
    endcase
  endfunction

  // Replace only the addressed lane(s) of the old word with the new store data.
  function automatic logic [DATA_WIDTH-1:0] mergeStore(input logic [DATA_WIDTH-1:0] oldWord,
                                                       input logic [DATA_WIDTH-1:0] newData,
                                                       input logic [1:0] off,
                                                       input logic [1:0] size);
    logic [DATA_WIDTH-1:0] mask;
    logic [DATA_WIDTH-1:0] shifted;
    logic [4:0]            shamt;
    shamt = (size == 2'b00) ? {off, 3'b000} : {off[1], 4'b0000};
    mask  = ((size == 2'b00) ? DATA_WIDTH'(8'hFF) : DATA_WIDTH'(16'hFFFF)) << shamt;
    shifted = newData << shamt;
    mergeStore = (oldWord & ~mask) | (shifted & mask);
  endfunction

  assign accept = (state == IDLE) && bus.req_valid;

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // Misalignment flag is captured at acceptance and reported in RESP.
  always_ff @(posedge clk) begin
    if (rst)         errReg <= 1'b0;
    else if (accept) errReg <= isMisaligned(bus.req_size, bus.req_addr[1:0]);
  end

  // Request capture, RMW merge in RD, load extraction at ACC exit.
  always_ff @(posedge clk) begin
    if (accept) begin
      addrReg   <= bus.req_addr;
      sizeReg   <= bus.req_size;
      signedReg <= bus.req_signed;
      writeReg  <= bus.req_write;
      dataReg   <= bus.req_wdata;
    end else if (state == RD) begin
      dataReg <= mergeStore(bus.mem_readData, dataReg, addrReg[1:0], sizeReg);
    end else if (state == ACC) begin
      dataReg <= extractLoad(bus.mem_readData, addrReg[1:0], sizeReg, signedReg);
    end
  end

  // Next-state and all bus outputs decoded from the current state.
  always_comb begin
    stateNext           = state;
    bus.req_ready       = 1'b0;
    bus.resp_valid      = 1'b0;
    bus.resp_rdata      = '0;
    bus.misalign_err    = 1'b0;
    bus.mem_address     = '0;
    bus.mem_writeData   = '0;
    bus.mem_writeEnable = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          if (isMisaligned(bus.req_size, bus.req_addr[1:0])) stateNext = RESP;
          else if (!bus.req_write)                           stateNext = ACC;
          else if (bus.req_size == 2'b10)                    stateNext = WR;
          else                                               stateNext = RD;
        end
      end
      RD: begin
        bus.mem_address = addrReg[ADDR_WIDTH+1:2];
        stateNext       = WR;
      end
      WR: begin
        bus.mem_address     = addrReg[ADDR_WIDTH+1:2];
        bus.mem_writeData   = dataReg;
        bus.mem_writeEnable = 1'b1;
        stateNext           = RESP;
      end
      ACC: begin
        bus.mem_address = addrReg[ADDR_WIDTH+1:2];
        stateNext       = RESP;
      end
      RESP: begin
        bus.mem_address  = addrReg[ADDR_WIDTH+1:2];
        bus.resp_valid   = 1'b1;
        bus.misalign_err = errReg;
        // Stores and misaligned requests return zero data.
        if (!writeReg && !errReg) bus.resp_rdata = dataReg;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, memory word width (only 32 supported).
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, DataMemory word-address width; the byte address is ADDR_WIDTH+2 bits.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have ports req_valid input 1, req_ready output 1: request handshake; transfer when both are high at a rising edge.
REQ-006 SHALL have ports req_write input 1 (1 = store), req_size input 2 (00 byte, 01 half, 10 word, 11 illegal), req_signed input 1 (load sign-extend).
REQ-007 SHALL have ports req_addr input ADDR_WIDTH+2 (byte address) and req_wdata input 32 (store data, right-aligned).
REQ-008 SHALL have ports resp_valid output 1, resp_rdata output 32, misalign_err output 1.
REQ-009 SHALL have ports mem_address output ADDR_WIDTH, mem_writeData output 32, mem_writeEnable output 1, mem_readData input 32, connecting to DataMemory (combinational read, write on clk edge when mem_writeEnable is high).

Function
REQ-010 SHALL use FSM states IDLE, RD, WR, ACC, RESP; req_ready = 1 only in IDLE.
REQ-011 On acceptance SHALL register req_addr, size, signed, write and wdata; later input changes have no effect.
REQ-012 Misaligned: half with addr[0]=1, word with addr[1:0]!=0, or size 11; SHALL go IDLE->RESP, misalign_err=1, resp_rdata=0, no memory access.
REQ-013 Load: IDLE->ACC->RESP; in ACC, mem_address = addr[ADDR_WIDTH+1:2]; extracted data registered at ACC exit; resp_valid 2 cycles after acceptance.
REQ-014 Word store: IDLE->WR->RESP; in WR, mem_writeEnable=1, mem_writeData=wdata.
REQ-015 Byte/half store: IDLE->RD->WR->RESP; in RD, read word; merge new lanes, keep others; write merged word in WR.
REQ-016 Byte lanes little-endian: offset 0 = bits 7:0, offset 3 = bits 31:24; half offset 0 = bits 15:0, 2 = bits 31:16.
REQ-017 Loads SHALL zero-extend when req_signed=0, sign-extend from bit 7/15 when 1; word loads ignore req_signed.
REQ-018 resp_valid SHALL pulse exactly one cycle (RESP), then IDLE; no backpressure; stores return resp_rdata=0, misalign_err=0.
REQ-019 mem_writeEnable SHALL be high only in WR, exactly one cycle per store, never for loads or misaligned requests.
REQ-020 mem_address SHALL be the registered word address outside IDLE, and 0 in IDLE.
REQ-021 A request held valid during a busy operation SHALL be accepted only in the first IDLE cycle after RESP (back-to-back throughput: one op per 2-4 cycles).

Reset
REQ-022 With rst high at an edge, next cycle: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, misalign_err=0, mem_writeEnable=0, mem_address=0.
REQ-023 Reset mid-operation SHALL abort it: no pending write issued, no response generated.
REQ-024 Requests with req_valid high while rst is high SHALL NOT be accepted.

Verification
REQ-025 SW 0x11223344 @0x004 -> mem_writeEnable high one cycle at T+1, mem_address=0x01; then LW @0x004 -> resp_valid at T+2, resp_rdata=0x11223344.
REQ-026 SB 0x000000EE @0x005 over 0x11223344 -> word 0x1122EE44; LBU @0x005 -> 0x000000EE; LB @0x005 -> 0xFFFFFFEE.
REQ-027 SH 0x00008001 @0x006 -> word 0x8001EE44; LH @0x006 -> 0xFFFF8001; LHU -> 0x00008001; RMW store resp at T+3.
REQ-028 LW @0x002, LH @0x001, size 11 -> resp_valid at T+1, misalign_err=1, resp_rdata=0, mem_writeEnable never high.
REQ-029 SB @0x004 with rst pulsed during RD -> no write, word unchanged, req_ready=1 after reset, no resp_valid.
REQ-030 req_valid held high for two queued loads -> second accepted exactly the cycle after first resp_valid; responses in order.
